// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer behind the Uart8 receiver, with overrun flag and fill level.
// Optional framing-error counter enabled by defining UART_RX_FIFO_ERRCNT_EN.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        rxDone,
    input  logic        rxErr,
    input  logic [7:0]  rxByte,
    input  logic        outReady,
    output logic        outValid,
    output logic [7:0]  outByte,
    output logic [AW:0] level,
    output logic        full,
    output logic        overrun,
    input  logic        clrFlags,
    output logic [7:0]  errCount
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          rxDonePrev;
    logic          push;
    logic          pop;
    logic          wrEn;

    assign push     = rxDone & ~rxDonePrev;
    assign outValid = (level != '0);
    assign full     = (level == FULL_LEVEL);
    assign pop      = outValid & outReady;
    // At full, a same-cycle pop frees the slot the write lands in (wp == rp).
    assign wrEn     = push & (~full | pop);
    assign outByte  = mem[rp];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxDonePrev <= 1'b1;
            wp         <= '0;
            rp         <= '0;
            level      <= '0;
            overrun    <= 1'b0;
            // NOTE: the memory is reset because outByte must read 0 after reset, not X.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            rxDonePrev <= rxDone;
            if (wrEn) begin
                mem[wp] <= rxByte;
                wp      <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (wrEn && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !wrEn) begin
                level <= level - 1'b1;
            end
            if (clrFlags) begin
                overrun <= 1'b0;
            end else if (push && full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef UART_RX_FIFO_ERRCNT_EN
    logic rxErrPrev;
    logic errEvt;

    assign errEvt = rxErr & ~rxErrPrev;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxErrPrev <= 1'b1;
            errCount  <= 8'h00;
        end else begin
            rxErrPrev <= rxErr;
            if (clrFlags) begin
                errCount <= 8'h00;
            end else if (errEvt && errCount != 8'hFF) begin
                errCount <= errCount + 8'h01;
            end
        end
    end
`else
    logic unusedRxErr;

    assign unusedRxErr = rxErr;
    assign errCount    = 8'h00;
`endif

endmodule
